// File: rtl/nn_job_dispatcher.sv
// Initiator-side job dispatcher for the neuron engine: packs four serial words
// into x1..x4, pulses start, waits for done (with watchdog) and returns the result.
`timescale 1ns/1ps
module nn_job_dispatcher #(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [N-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         nn_start_o,
  output logic [N-1:0] nn_x1_o,
  output logic [N-1:0] nn_x2_o,
  output logic [N-1:0] nn_x3_o,
  output logic [N-1:0] nn_x4_o,
  input  logic         nn_done_i,
  input  logic [N-1:0] nn_out_i,
  output logic         res_valid_o,
  output logic [N-1:0] res_data_o,
  output logic         res_timeout_o,
  input  logic         res_ready_i,
  output logic         busy_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESULT  = 2'd3
  } state_e;

  state_e        state_q;
  logic [1:0]    idx_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  logic          in_ready_q;
  logic          nn_start_q;
  logic [N-1:0]  x1_q, x2_q, x3_q, x4_q;
  logic          res_valid_q;
  logic [N-1:0]  res_data_q;
  logic          res_timeout_q;
  logic          busy_q;
  logic          accept_c;

  assign accept_c = in_valid_i & in_ready_q;
  // Expiry is judged on the incremented count, so the result appears
  // TIMEOUT cycles after the start pulse.
  assign timer_d  = timer_q + TW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_COLLECT;
      idx_q         <= 2'd0;
      timer_q       <= '0;
      in_ready_q    <= 1'b0;
      nn_start_q    <= 1'b0;
      x1_q          <= '0;
      x2_q          <= '0;
      x3_q          <= '0;
      x4_q          <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          in_ready_q <= 1'b1;
          if (accept_c) begin
            unique case (idx_q)
              2'd0:    x1_q <= in_data_i;
              2'd1:    x2_q <= in_data_i;
              2'd2:    x3_q <= in_data_i;
              default: x4_q <= in_data_i;
            endcase
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q    <= S_START;
              in_ready_q <= 1'b0;
              nn_start_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        // Any done seen here belongs to a previous job and is dropped.
        S_START: begin
          nn_start_q <= 1'b0;
          timer_q    <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          timer_q <= timer_d;
          if (nn_done_i) begin
            res_data_q    <= nn_out_i;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state_q       <= S_RESULT;
          end else if (timer_d == TW'(TIMEOUT - 1)) begin
            res_data_q    <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            state_q       <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            idx_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_COLLECT;
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign nn_start_o    = nn_start_q;
  assign nn_x1_o       = x1_q;
  assign nn_x2_o       = x2_q;
  assign nn_x3_o       = x3_q;
  assign nn_x4_o       = x4_q;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_timeout_o = res_timeout_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_nn_job_dispatcher.sv
// Self-checking bench for nn_job_dispatcher: directed vector table, random jobs
// against a cycle-count reference model, and a mid-job reset sequence.
`timescale 1ns/1ps
module tb_nn_job_dispatcher;

  localparam int unsigned N       = 32;
  localparam int unsigned TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         nn_start;
  logic [N-1:0] x1, x2, x3, x4;
  logic         nn_done;
  logic [N-1:0] nn_out;
  logic         res_valid;
  logic [N-1:0] res_data;
  logic         res_timeout;
  logic         res_ready;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  nn_job_dispatcher #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .nn_start_o   (nn_start),
    .nn_x1_o      (x1),
    .nn_x2_o      (x2),
    .nn_x3_o      (x3),
    .nn_x4_o      (x4),
    .nn_done_i    (nn_done),
    .nn_out_i     (nn_out),
    .res_valid_o  (res_valid),
    .res_data_o   (res_data),
    .res_timeout_o(res_timeout),
    .res_ready_i  (res_ready),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // One job: operands, bubble position (4 = none), engine done cycle k counted
  // from the start cycle (<0 = never), done also in START, result-ready delay.
  typedef struct {
    logic [3:0][N-1:0] w;
    int                bub;
    int                k;
    bit                dstart;
    logic [N-1:0]      eout;
    int                rdly;
    int                lat;
    logic [N-1:0]      d;
    bit                to;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Engine has TIMEOUT-1 waiting cycles after START to answer; otherwise timeout.
  function automatic void model(input int k, input logic [N-1:0] eout,
                                output int lat, output logic [N-1:0] d, output bit to);
    if (k >= 1 && k <= int'(TIMEOUT) - 1) begin
      lat = k + 1; d = eout; to = 1'b0;
    end else begin
      lat = int'(TIMEOUT); d = '0; to = 1'b1;
    end
  endfunction

  function automatic logic any_output();
    return |{in_ready, nn_start, x1, x2, x3, x4, res_valid, res_data, res_timeout, busy};
  endfunction

  // Called just after a negedge; returns just after the negedge in the START cycle.
  task automatic send_words(input logic [3:0][N-1:0] w, input int bub);
    int  sent = 0;
    int  guard = 0;
    bit  bubbled = 1'b0;
    logic rdy_prev;
    while (sent < 4 && guard < 60) begin
      if (sent == bub && !bubbled) begin
        in_valid = 1'b0;
        bubbled  = 1'b1;
      end else begin
        in_valid = 1'b1;
        in_data  = w[sent];
      end
      rdy_prev = in_ready;
      @(negedge clk);
      guard++;
      if (in_valid && rdy_prev) sent++;
    end
    in_valid = 1'b0;
    check("words_accepted", 64'(sent), 64'd4);
  endtask

  task automatic run_job(input vec_t v);
    int   c = 0;
    int   res_c = -1;
    int   nstarts = 0;
    bit   start0 = 1'b0;
    bit   stable = 1'b1;
    bit   rdy_leak = 1'b0;
    bit   hold = 1'b1;
    send_words(v.w, v.bub);
    check("busy_in_start", 64'(busy), 64'd1);
    while (c < 100) begin
      if (res_valid) begin
        res_c = c;
        break;
      end
      if (nn_start) begin
        nstarts++;
        if (c == 0) start0 = 1'b1;
      end
      if ({x4, x3, x2, x1} !== v.w) stable = 1'b0;
      if (in_ready) rdy_leak = 1'b1;
      nn_done  = (c == v.k) || (c == 0 && v.dstart);
      nn_out   = (c == v.k) ? v.eout : N'($urandom);
      in_valid = 1'($urandom);
      in_data  = N'($urandom);
      @(negedge clk);
      c++;
    end
    nn_done  = 1'b0;
    in_valid = 1'b0;
    check("start_pulses", 64'(nstarts), 64'd1);
    check("start_first_cycle", 64'(start0), 64'd1);
    check("operands_held", 64'(stable), 64'd1);
    check("no_ready_while_busy", 64'(rdy_leak), 64'd0);
    check("result_latency", 64'(res_c), 64'(v.lat));
    check("res_data", 64'(res_data), 64'(v.d));
    check("res_timeout", 64'(res_timeout), 64'(v.to));
    res_ready = 1'b0;
    for (int i = 0; i < v.rdly; i++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom);
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== v.d || in_ready !== 1'b0) hold = 1'b0;
    end
    if (v.rdly > 0) check("result_held", 64'(hold), 64'd1);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_dropped", 64'(res_valid), 64'd0);
    check("ready_after_result", 64'(in_ready), 64'd1);
    check("busy_after_result", 64'(busy), 64'd0);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; nn_done = 1'b0;
    nn_out = '0; res_ready = 1'b0;

    vecs[0] = '{w: {32'd4, 32'd3, 32'd2, 32'd1}, bub: 4, k: 5, dstart: 0, eout: 32'd10,
                rdly: 0, lat: 6, d: 32'd10, to: 0};
    vecs[1] = '{w: {32'h44, 32'h33, 32'h22, 32'h11}, bub: 2, k: 3, dstart: 0, eout: 32'hABCD,
                rdly: 1, lat: 4, d: 32'hABCD, to: 0};
    vecs[2] = '{w: {32'd8, 32'd7, 32'd6, 32'd5}, bub: 4, k: -1, dstart: 0, eout: 32'h55,
                rdly: 0, lat: 16, d: 32'd0, to: 1};
    vecs[3] = '{w: {32'hD, 32'hC, 32'hB, 32'hA}, bub: 0, k: 2, dstart: 0, eout: 32'h77,
                rdly: 7, lat: 3, d: 32'h77, to: 0};
    vecs[4] = '{w: {32'h1, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000}, bub: 4, k: 15, dstart: 1,
                eout: 32'hBEEF, rdly: 2, lat: 16, d: 32'hBEEF, to: 0};
    vecs[5] = '{w: {32'h5, 32'h6, 32'h7, 32'h8}, bub: 3, k: 1, dstart: 0, eout: 32'h1234,
                rdly: 0, lat: 2, d: 32'h1234, to: 0};
    vecs[6] = '{w: {32'h9, 32'h9, 32'h9, 32'h9}, bub: 1, k: 16, dstart: 0, eout: 32'h99,
                rdly: 0, lat: 16, d: 32'd0, to: 1};
    vecs[7] = '{w: {32'h2, 32'h4, 32'h6, 32'h8}, bub: 4, k: -1, dstart: 1, eout: 32'h66,
                rdly: 1, lat: 16, d: 32'd0, to: 1};

    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 64'(any_output()), 64'd0);
    #2 rst_n = 1'b1;
    #1 check("ready_low_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);

    foreach (vecs[i]) run_job(vecs[i]);

    for (int j = 0; j < 25; j++) begin
      for (int b = 0; b < 4; b++) rv.w[b] = N'($urandom);
      rv.bub    = int'($urandom_range(0, 4));
      rv.k      = int'($urandom_range(0, 20));
      rv.dstart = 1'($urandom);
      rv.eout   = N'($urandom);
      rv.rdly   = int'($urandom_range(0, 3));
      model(rv.k, rv.eout, rv.lat, rv.d, rv.to);
      run_job(rv);
    end

    // Reset while waiting on the engine, then a clean job afterwards.
    rv.w = {32'hF4, 32'hF3, 32'hF2, 32'hF1};
    send_words(rv.w, 4);
    repeat (3) @(negedge clk);
    check("busy_before_abort", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1 check("async_reset_zero", 64'(any_output()), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_abort", 64'(in_ready), 64'd1);
    check("operands_cleared", 64'(x1), 64'd0);
    rv = '{w: {32'h40, 32'h30, 32'h20, 32'h10}, bub: 4, k: 4, dstart: 0, eout: 32'hCAFE,
           rdly: 1, lat: 5, d: 32'hCAFE, to: 0};
    run_job(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
